regfile_mp: RTL

Parametrised multi-port register file for the pipelined CPU datapath. Key features:
- NUM_RD combinational read ports and two prioritised write ports.
- Optional write-to-read bypass and a hardwired zero register.
- Per-register pending scoreboard for hazard detection.
- Sequential re-initialisation sweep FSM.

Sits between decode (reads, pending check, issue-time pending set) and writeback (write ports).

---
 rtl/regfile_mp.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
// Module   : regfile_mp
// Purpose  : Parametrised multi-port register file for the pipelined CPU
//            datapath. It provides NUM_RD combinational read ports and two
//            prioritised write ports (port 1 wins). It also has an optional
//            write-to-read bypass, an optional hardwired zero register, a
//            per-register pending scoreboard and a sequential
//            re-initialisation sweep.
// Ports    : clk        - clock, all state updates on posedge
//            rst_n      - asynchronous active-low reset
//            rd_addr    - packed read addresses, port k at [k*ADDR_W +: ADDR_W]
//            rd_data    - packed read data, port k at [k*DATA_W +: DATA_W]
//            rd_pend    - pending bit of each addressed register
//            we0/wa0/wd0 - write port 0
//            we1/wa1/wd1 - write port 1 (higher priority)
//            pend_set   - mark pend_addr pending (instruction issue)
//            pend_addr  - register to mark pending
//            init_req   - single-cycle pulse starting the init sweep
//            busy       - high while the init sweep runs
// Revision : 1.0 - initial release
// ============================================================================
module regfile_mp #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int NUM_RD     = 2,
  parameter int BYPASS     = 1,
  parameter int ZERO_REG   = 1,
  parameter int INIT_INDEX = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic [NUM_RD-1:0]          rd_pend,
  input  logic                       we0,
  input  logic [ADDR_W-1:0]          wa0,
  input  logic [DATA_W-1:0]          wd0,
  input  logic                       we1,
  input  logic [ADDR_W-1:0]          wa1,
  input  logic [DATA_W-1:0]          wd1,
  input  logic                       pend_set,
  input  logic [ADDR_W-1:0]          pend_addr,
  input  logic                       init_req,
  output logic                       busy
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_PTR = '1;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } state_t;

  // Init value of an entry: its own index (zero-extended / truncated) or 0.
  function automatic logic [DATA_W-1:0] init_val(input logic [ADDR_W-1:0] idx);
    logic [DATA_W-1:0] v;
    v = '0;
    if (INIT_INDEX != 0) begin
      for (int b = 0; b < DATA_W; b++) begin
        if (b < ADDR_W) v[b] = idx[b];
      end
    end
    return v;
  endfunction

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [DATA_W-1:0] mem_q  [DEPTH];
  logic [DATA_W-1:0] mem_d  [DEPTH];
  logic [DEPTH-1:0]  pend_q;
  logic [DEPTH-1:0]  pend_d;
  state_t            state_q;
  state_t            state_d;
  logic [ADDR_W-1:0] ptr_q;
  logic [ADDR_W-1:0] ptr_d;

  logic busy_int;
  assign busy_int = (state_q == ST_SWEEP);
  assign busy     = busy_int;

  // Effective request qualifiers: everything is gated off during the sweep,
  // and entry 0 is untouchable when it is the hardwired zero register.
  logic we0_eff;
  logic we1_eff;
  logic pset_eff;

  assign we0_eff  = we0 && !busy_int && !((ZERO_REG != 0) && (wa0 == '0));
  assign we1_eff  = we1 && !busy_int && !((ZERO_REG != 0) && (wa1 == '0));
  assign pset_eff = pend_set && !busy_int && !((ZERO_REG != 0) && (pend_addr == '0));

  // --------------------------------------------------------------------------
  // Sweep FSM next state
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_IDLE: begin
        ptr_d = '0;
        if (init_req) state_d = ST_SWEEP;
      end
      ST_SWEEP: begin
        // Pointer wraps naturally; the last entry ends the sweep.
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == LAST_PTR) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        ptr_d   = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Storage and scoreboard next state
  // --------------------------------------------------------------------------
  always_comb begin
    mem_d  = mem_q;
    pend_d = pend_q;
    if (busy_int) begin
      mem_d[ptr_q]  = init_val(ptr_q);
      pend_d[ptr_q] = 1'b0;
    end else begin
      // Port 1 is applied last so it wins an address collision.
      if (we0_eff) begin
        mem_d[wa0]  = wd0;
        pend_d[wa0] = 1'b0;
      end
      if (we1_eff) begin
        mem_d[wa1]  = wd1;
        pend_d[wa1] = 1'b0;
      end
      // A new producer issued in the same cycle as the writeback keeps the
      // register pending, so the set is applied after the write clears.
      if (pset_eff) pend_d[pend_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= init_val(ADDR_W'(i));
      end
      pend_q  <= '0;
      state_q <= ST_IDLE;
      ptr_q   <= '0;
    end else begin
      mem_q   <= mem_d;
      pend_q  <= pend_d;
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // --------------------------------------------------------------------------
  // Read ports
  // --------------------------------------------------------------------------
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              pend;

    assign addr = rd_addr[k*ADDR_W +: ADDR_W];

    always_comb begin
      data = mem_q[addr];
      pend = pend_q[addr];
      if ((BYPASS != 0) && !busy_int) begin
        // The effective enables already exclude the sweep and the zero
        // register, so the bypass never forwards a dropped write.
        if (we1_eff && (wa1 == addr)) begin
          data = wd1;
          pend = pset_eff && (pend_addr == addr);
        end else if (we0_eff && (wa0 == addr)) begin
          data = wd0;
          pend = pset_eff && (pend_addr == addr);
        end
      end
      if ((ZERO_REG != 0) && (addr == '0)) begin
        data = '0;
        pend = 1'b0;
      end
    end

    assign rd_data[k*DATA_W +: DATA_W] = data;
    assign rd_pend[k]                  = pend;
  end

endmodule
`default_nettype wire
